synaptic_input_accumulator: RTL and testbench
=============================================

Name: synaptic_input_accumulator

Overview:
- Upstream stage of the LIF neuron.
- Accepts presynaptic spike events over a valid/ready handshake and adds a programmable per-synapse weight for each accepted event.
- On each timestep tick, folds the window sum into a leaky synaptic current and presents it to the neuron as a one-cycle signed 8-bit input_current pulse.
- Between updates, input_current is 0, so the neuron integrates exactly once per timestep.

Parameters:
- NUM_SYN, 8, number of synapses (weight registers); must be >= 2.
- W_WIDTH, 8, signed weight width.
- ACC_WIDTH, 16, signed width of the window accumulator and the synaptic current register.
- TAU_SHIFT, 2, synaptic current decay per tick: I <= I - (I >>> TAU_SHIFT).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- tick  in  1  timestep strobe, one cycle wide.
- ev_valid  in  1  presynaptic event valid.
- ev_ready  out  1  event accept; an event transfers when ev_valid && ev_ready.
- ev_syn  in  $clog2(NUM_SYN)  synapse index of the event.
- wr_en  in  1  weight write strobe.
- wr_addr  in  $clog2(NUM_SYN)  weight index.
- wr_data  in  W_WIDTH signed  weight value.
- input_current  out  8 signed  saturated current to the neuron; nonzero only when cur_valid=1.
- cur_valid  out  1  one-cycle update pulse.
- sat_flag  out  1  high with cur_valid when input_current was clipped.
- tick_miss  out  1  one-cycle pulse when a tick arrives outside ACCUM.

Behaviour:
- Reset is synchronous and active-high; one clock (clk).
- On reset:
  - weights = 0, acc = 0, I_syn = 0, state = ACCUM.
  - input_current = 0, cur_valid = 0, sat_flag = 0, tick_miss = 0.
  - ev_ready = 1 from the first cycle after reset.
- FSM, three states:
  - ACCUM:
    - ev_ready = 1.
    - Each accepted event does acc <= sat_ACC(acc + sext(weight[ev_syn])).
    - On tick go to DECAY. An event accepted in the same cycle as the tick belongs to the closing window.
  - DECAY:
    - ev_ready = 0.
    - I_syn <= sat_ACC(I_syn - (I_syn >>> TAU_SHIFT) + acc); acc <= 0.
    - Go to EMIT.
  - EMIT:
    - ev_ready = 0.
    - input_current <= sat8(I_syn); cur_valid <= 1; sat_flag <= (I_syn > 127 || I_syn < -128).
    - Go to ACCUM.
- Output registers: input_current, cur_valid and sat_flag are registered. They return to 0 on the cycle after the pulse.
- Latency: tick sampled at edge N → cur_valid high during cycle N+2 (registered from EMIT). The next window's events are accepted from cycle N+2.
- Arithmetic:
  - sat_ACC clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - sat8 clamps to [-128, 127].
  - The shift is arithmetic (rounds toward -inf). Small positive I_syn (< 2^TAU_SHIFT) therefore never decays to 0, and -1 decays to 0; this is the intended behaviour.
  - I_syn is never clipped to 8 bits internally; only the output is.
- Tick in DECAY or EMIT: ignored (no extra update); tick_miss pulses the next cycle.
- Weight write: allowed in any state. A write in the same cycle as an event to the same index means the event uses the old weight; the new weight is visible the next cycle.
- Out-of-range ev_syn or wr_addr (when NUM_SYN is not a power of 2): the event is accepted with weight 0, and the write is dropped.
- Reset mid-operation (any state): all state clears on the next edge, with no cur_valid pulse for the aborted window.

Decomposition:
- Shared neuro package:
  - FSM state enum (ACCUM, DECAY, EMIT).
  - Function sat(value, width) for signed clamping, reused by the neuron-side blocks.
  - CURRENT_WIDTH = 8 (neuron input width).
- One sub-module: synapse_weight_regfile. NUM_SYN×W_WIDTH registers, one write port, one combinational read port, synchronous reset to 0.

Test Plan:
- Reset, then tick with no events → cur_valid exactly 2 cycles after the tick, input_current=0, sat_flag=0.
- weight[0]=20, 3 events on syn0, tick → input_current=60. Tick with no events → 45. Next tick → 34 (45 - 11).
- weight[0]=100, 2 events, tick → input_current=127, sat_flag=1 (I_syn=200). Next empty tick → I_syn=150, output 127, sat_flag=1.
- weight[1]=-50, 4 events, tick → input_current=-128, sat_flag=1. Event on syn1 asserted in the same cycle as the tick is counted (5 events → I_syn=-250).
- Tick during DECAY → tick_miss=1, exactly one cur_valid. ev_ready=0 in DECAY/EMIT, and held ev_valid transfers when ACCUM resumes.
- wr_en to addr 0 (5→9) in the same cycle as a syn0 event → window sum 5; next event adds 9. Assert rst during DECAY → no cur_valid, all outputs 0, ev_ready=1 one cycle after release.

Source files
------------

// File: rtl/synaptic_input_accumulator_pkg.sv
// Purpose: shared neuron-side types, widths and signed clamping helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package synaptic_input_accumulator_pkg;

    // Width of the current presented to the LIF neuron.
    localparam int CURRENT_WIDTH = 8;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DECAY = 2'd1,
        EMIT  = 2'd2
    } state_t;

    // Clamp a signed value to the range of a signed 'width'-bit number.
    // Callers keep their operands well inside 32 bits, so the wide
    // intermediate never wraps before the clamp.
    function automatic logic signed [31:0] sat(input logic signed [31:0] value,
                                               input int                 width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/synaptic_input_accumulator_if.sv
// Purpose: event handshake, weight write port and neuron current output bundle.
// Latency: n/a (wiring only).
// Backpressure: ev_ready from the slave throttles ev_valid from the master.
//
// Signals:
//   tick          timestep strobe (master -> slave)
//   ev_valid/ev_ready/ev_syn   presynaptic event handshake and synapse index
//   wr_en/wr_addr/wr_data      weight write port
//   input_current/cur_valid/sat_flag  per-timestep current pulse to the neuron
//   tick_miss     pulse when a tick arrived while busy updating
interface synaptic_input_accumulator_if #(
    parameter int NUM_SYN = 8,
    parameter int W_WIDTH = 8
);
    import synaptic_input_accumulator_pkg::*;

    localparam int SYN_W = $clog2(NUM_SYN);

    logic                            tick;
    logic                            ev_valid;
    logic                            ev_ready;
    logic [SYN_W-1:0]                ev_syn;
    logic                            wr_en;
    logic [SYN_W-1:0]                wr_addr;
    logic signed [W_WIDTH-1:0]       wr_data;
    logic signed [CURRENT_WIDTH-1:0] input_current;
    logic                            cur_valid;
    logic                            sat_flag;
    logic                            tick_miss;

    modport master (
        output tick, ev_valid, ev_syn, wr_en, wr_addr, wr_data,
        input  ev_ready, input_current, cur_valid, sat_flag, tick_miss
    );

    modport slave (
        input  tick, ev_valid, ev_syn, wr_en, wr_addr, wr_data,
        output ev_ready, input_current, cur_valid, sat_flag, tick_miss
    );

endinterface

// File: rtl/synaptic_input_accumulator_synapse_weight_regfile.sv
// Purpose: NUM_SYN x W_WIDTH signed weight registers, one write and one read port.
// Latency: write visible the cycle after wr_en; read is combinational.
// Backpressure: none; writes always accepted, out-of-range writes dropped.
//
// Ports: clk, rst (sync, active-high), wr_en/wr_addr/wr_data write port,
//        rd_addr/rd_data read port (out-of-range index reads as 0).
module synapse_weight_regfile #(
    parameter int NUM_SYN = 8,
    parameter int W_WIDTH = 8,
    parameter int ADDR_W  = $clog2(NUM_SYN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic signed [W_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic signed [W_WIDTH-1:0] rd_data
);

    logic signed [W_WIDTH-1:0] mem [NUM_SYN];

    // Decoding by comparison against each implemented index makes any
    // address beyond NUM_SYN-1 match nothing: writes drop, reads give 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SYN; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_SYN; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_SYN; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = mem[i];
            end
        end
    end

endmodule

// File: rtl/synaptic_input_accumulator.sv
// Purpose: sums weighted presynaptic events per timestep into a leaky synaptic current.
// Latency: tick at edge N -> cur_valid/input_current pulse during cycle N+2.
// Backpressure: ev_ready low for the two update cycles after a tick; events wait.
//
// Ports: clk, rst (sync, active-high), bus (slave modport): tick, event
//        handshake, weight write port, input_current/cur_valid/sat_flag
//        output pulse and tick_miss.
module synaptic_input_accumulator
    import synaptic_input_accumulator_pkg::*;
#(
    parameter int NUM_SYN   = 8,
    parameter int W_WIDTH   = 8,
    parameter int ACC_WIDTH = 16,
    parameter int TAU_SHIFT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    synaptic_input_accumulator_if.slave   bus
);

    localparam int SYN_W = $clog2(NUM_SYN);

    state_t                          state_q, state_d;
    logic signed [ACC_WIDTH-1:0]     acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]     isyn_q, isyn_d;
    logic signed [CURRENT_WIDTH-1:0] cur_q, cur_d;
    logic                            cur_vld_q, cur_vld_d;
    logic                            sat_q, sat_d;
    logic                            miss_q, miss_d;

    logic                            ev_fire;
    logic signed [W_WIDTH-1:0]       wt_rd;

    // Read is combinational off the stored array, so an event in the same
    // cycle as a write to its index sees the old weight.
    synapse_weight_regfile #(
        .NUM_SYN (NUM_SYN),
        .W_WIDTH (W_WIDTH),
        .ADDR_W  (SYN_W)
    ) u_weights (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (bus.ev_syn),
        .rd_data (wt_rd)
    );

    assign bus.ev_ready = (state_q == ACCUM);
    assign ev_fire      = bus.ev_valid && bus.ev_ready;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        isyn_d    = isyn_q;
        cur_d     = '0;
        cur_vld_d = 1'b0;
        sat_d     = 1'b0;
        miss_d    = 1'b0;

        case (state_q)
            ACCUM: begin
                // An event coinciding with the tick is still added here,
                // so it lands in the window being closed.
                if (ev_fire) begin
                    acc_d = ACC_WIDTH'(sat(32'(acc_q) + 32'(wt_rd), ACC_WIDTH));
                end
                if (bus.tick) begin
                    state_d = DECAY;
                end
            end
            DECAY: begin
                // Arithmetic shift floors, so small positives hold their
                // value and -1 decays to 0.
                isyn_d  = ACC_WIDTH'(sat(32'(isyn_q) - (32'(isyn_q) >>> TAU_SHIFT)
                                         + 32'(acc_q), ACC_WIDTH));
                acc_d   = '0;
                miss_d  = bus.tick;
                state_d = EMIT;
            end
            EMIT: begin
                // Only the neuron-facing value is clipped; isyn_q keeps full width.
                cur_d     = CURRENT_WIDTH'(sat(32'(isyn_q), CURRENT_WIDTH));
                cur_vld_d = 1'b1;
                sat_d     = (sat(32'(isyn_q), CURRENT_WIDTH) != 32'(isyn_q));
                miss_d    = bus.tick;
                state_d   = ACCUM;
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            isyn_q    <= '0;
            cur_q     <= '0;
            cur_vld_q <= 1'b0;
            sat_q     <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            isyn_q    <= isyn_d;
            cur_q     <= cur_d;
            cur_vld_q <= cur_vld_d;
            sat_q     <= sat_d;
            miss_q    <= miss_d;
        end
    end

    assign bus.input_current = cur_q;
    assign bus.cur_valid     = cur_vld_q;
    assign bus.sat_flag      = sat_q;
    assign bus.tick_miss     = miss_q;

endmodule

// File: tb/tb_synaptic_input_accumulator.sv
// Purpose: directed, table-driven bench for synaptic_input_accumulator.
// Latency: checks the tick -> cur_valid distance of two cycles.
// Backpressure: exercises ev_ready low during the update cycles.
module tb_synaptic_input_accumulator;

    logic clk;
    logic rst;

    int n_tests;
    int n_fail;

    synaptic_input_accumulator_if #(.NUM_SYN(8), .W_WIDTH(8)) bus();

    synaptic_input_accumulator #(
        .NUM_SYN   (8),
        .W_WIDTH   (8),
        .ACC_WIDTH (16),
        .TAU_SHIFT (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst_first;
        bit w_en;
        int w_idx;
        int w_val;
        int syn;
        int n_ev;
        bit ev_on_tick;
        int exp_cur;
        bit exp_sat;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vec [NVEC];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.tick     = 1'b0;
        bus.ev_valid = 1'b0;
        bus.ev_syn   = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic write_w(input int idx, input int val);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(idx);
        bus.wr_data = 8'(val);
        step();
        bus.wr_en   = 1'b0;
    endtask

    // Waits (bounded) for cur_valid; lat = cycles after the tick edge, -1 on timeout.
    task automatic wait_pulse(output int lat);
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (bus.cur_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic send_tick();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
    endtask

    initial begin
        int lat;
        int pulses;
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        idle_inputs();

        //         rst w_en idx  val  syn n_ev on_tick cur  sat
        vec[0]  = '{1, 0,   0,   0,   0,  0,   0,      0,   0};
        vec[1]  = '{0, 1,   0,   20,  0,  3,   0,      60,  0};
        vec[2]  = '{0, 0,   0,   0,   0,  0,   0,      45,  0};
        vec[3]  = '{0, 0,   0,   0,   0,  0,   0,      34,  0};
        vec[4]  = '{1, 1,   0,   100, 0,  2,   0,      127, 1};
        vec[5]  = '{0, 0,   0,   0,   0,  0,   0,      127, 1};
        vec[6]  = '{1, 1,   1,   -50, 1,  4,   1,     -128, 1};
        vec[7]  = '{0, 0,   0,   0,   0,  0,   0,     -128, 1};
        vec[8]  = '{1, 1,   1,   -5,  1,  4,   1,     -25,  0};
        vec[9]  = '{0, 0,   0,   0,   0,  0,   0,     -18,  0};
        vec[10] = '{1, 1,   0,   3,   0,  1,   0,      3,   0};
        vec[11] = '{0, 0,   0,   0,   0,  0,   0,      3,   0};
        vec[12] = '{0, 1,   2,  -128, 2,  1,   0,     -125, 0};
        vec[13] = '{0, 1,   7,   127, 7,  2,   0,      127, 1};

        do_reset();
        check("reset_cur_valid", int'(bus.cur_valid), 0);
        check("reset_input_current", int'(bus.input_current), 0);
        check("reset_sat_flag", int'(bus.sat_flag), 0);
        check("reset_tick_miss", int'(bus.tick_miss), 0);
        check("reset_ev_ready", int'(bus.ev_ready), 1);

        for (int i = 0; i < NVEC; i++) begin
            if (vec[i].rst_first) do_reset();
            if (vec[i].w_en) write_w(vec[i].w_idx, vec[i].w_val);
            for (int k = 0; k < vec[i].n_ev; k++) begin
                bus.ev_valid = 1'b1;
                bus.ev_syn   = 3'(vec[i].syn);
                step();
            end
            bus.ev_valid = vec[i].ev_on_tick;
            bus.ev_syn   = 3'(vec[i].syn);
            bus.tick     = 1'b1;
            step();
            bus.tick     = 1'b0;
            bus.ev_valid = 1'b0;
            wait_pulse(lat);
            check($sformatf("vec%0d_latency", i), lat, 2);
            check($sformatf("vec%0d_input_current", i), int'(bus.input_current), vec[i].exp_cur);
            check($sformatf("vec%0d_sat_flag", i), int'(bus.sat_flag), int'(vec[i].exp_sat));
            step();
            check($sformatf("vec%0d_pulse_end", i),
                  int'(bus.cur_valid) + int'(bus.input_current != 0) + int'(bus.sat_flag), 0);
        end

        // Tick during DECAY, and an event held across the busy cycles.
        do_reset();
        write_w(0, 7);
        send_tick();
        bus.tick     = 1'b1;
        bus.ev_valid = 1'b1;
        bus.ev_syn   = 3'd0;
        check("busy_decay_ev_ready", int'(bus.ev_ready), 0);
        step();
        bus.tick = 1'b0;
        pulses   = 0;
        check("busy_emit_ev_ready", int'(bus.ev_ready), 0);
        check("tick_miss_pulse", int'(bus.tick_miss), 1);
        step();
        if (bus.cur_valid) pulses++;
        check("resume_ev_ready", int'(bus.ev_ready), 1);
        check("tick_miss_clear", int'(bus.tick_miss), 0);
        step();
        bus.ev_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.cur_valid) pulses++;
            step();
        end
        check("single_cur_valid", pulses, 1);
        send_tick();
        wait_pulse(lat);
        check("held_event_latency", lat, 2);
        check("held_event_current", int'(bus.input_current), 7);

        // Weight write coinciding with an event on the same index.
        do_reset();
        write_w(0, 5);
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 3'd0;
        bus.wr_data  = 8'sd9;
        bus.ev_valid = 1'b1;
        bus.ev_syn   = 3'd0;
        step();
        bus.wr_en    = 1'b0;
        bus.ev_valid = 1'b0;
        send_tick();
        wait_pulse(lat);
        check("wr_same_cycle_old_weight", int'(bus.input_current), 5);
        step();
        bus.ev_valid = 1'b1;
        step();
        bus.ev_valid = 1'b0;
        send_tick();
        wait_pulse(lat);
        check("wr_same_cycle_new_weight", int'(bus.input_current), 13);

        // Reset asserted during DECAY aborts the update.
        step();
        bus.ev_valid = 1'b1;
        step();
        bus.ev_valid = 1'b0;
        send_tick();
        rst = 1'b1;
        step();
        rst = 1'b0;
        pulses = 0;
        step();
        check("rst_abort_ev_ready", int'(bus.ev_ready), 1);
        for (int k = 0; k < 6; k++) begin
            if (bus.cur_valid || bus.input_current != 0 || bus.sat_flag || bus.tick_miss) pulses++;
            step();
        end
        check("rst_abort_outputs_quiet", pulses, 0);
        bus.ev_valid = 1'b1;
        bus.ev_syn   = 3'd0;
        step();
        bus.ev_valid = 1'b0;
        send_tick();
        wait_pulse(lat);
        check("rst_abort_latency", lat, 2);
        check("rst_clears_weights", int'(bus.input_current), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
